// File: rtl/mul16s_acc_drain_if.sv
// Handshake bundle between the 16x16 multiplier, the accumulate/drain stage and
// the result/writeback path: product beats in, rounded dot-product results out.
interface mul16s_acc_drain_if #(
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
);
    logic             prod_valid;
    logic             prod_ready;
    logic [31:0]      prod_data;
    logic             prod_last;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    modport master (
        output prod_valid, prod_data, prod_last, clear, out_ready,
        input  prod_ready, out_valid, out_data, out_sat, out_count, busy
    );

    modport slave (
        input  prod_valid, prod_data, prod_last, clear, out_ready,
        output prod_ready, out_valid, out_data, out_sat, out_count, busy
    );
endinterface

// File: rtl/mul16s_acc_drain.sv
// Accumulates signed 32-bit products into an ACC_W accumulator; each last beat drains
// the sum through round-half-up shift and optional saturation into a result register.
module mul16s_acc_drain #(
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 0,
    parameter int SAT_EN = 1,
    parameter int CNT_W  = 16
) (
    input logic               clock,
    input logic               reset,
    mul16s_acc_drain_if.slave bus
);
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam int SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] HALF =
        (SHIFT > 0) ? ((ACC_W+1)'(1) << SHIFT_M1) : '0;
    localparam logic signed [ACC_W:0] OUT_MAX =
        {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

    state_t                  state, state_d;
    logic signed [ACC_W-1:0] acc, acc_d, sum;
    logic [CNT_W-1:0]        count, count_d, count_inc;
    logic signed [ACC_W:0]   rounded, shifted;
    logic [OUT_W-1:0]        drain_data;
    logic                    drain_sat;
    logic                    beat, load;

    // Ready looks only at the result register, so a held result back-pressures the multiplier.
    assign bus.prod_ready = !bus.out_valid || bus.out_ready;
    assign bus.busy       = (state == ACCUM);
    assign beat           = bus.prod_valid && bus.prod_ready;

    // acc is held at zero in IDLE, so one adder serves the first beat and later beats alike.
    assign sum       = acc + ACC_W'($signed(bus.prod_data));
    assign count_inc = (&count) ? count : count + CNT_W'(1);

    always_comb begin
        rounded    = {sum[ACC_W-1], sum} + HALF;
        shifted    = rounded >>> SHIFT;
        drain_data = shifted[OUT_W-1:0];
        drain_sat  = 1'b0;
        if (SAT_EN != 0) begin
            if (shifted > OUT_MAX) begin
                drain_data = OUT_MAX[OUT_W-1:0];
                drain_sat  = 1'b1;
            end else if (shifted < OUT_MIN) begin
                drain_data = OUT_MIN[OUT_W-1:0];
                drain_sat  = 1'b1;
            end
        end
    end

    // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d = state;
        acc_d   = acc;
        count_d = count;
        load    = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
        end else if (beat) begin
            if (bus.prod_last) begin
                load    = 1'b1;
                state_d = IDLE;
                acc_d   = '0;
                count_d = '0;
            end else begin
                state_d = ACCUM;
                acc_d   = sum;
                count_d = count_inc;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            count <= count_d;
        end
    end

    // A load on the same edge as a transfer wins, giving one result per cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
            bus.out_count <= '0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= drain_data;
            bus.out_sat   <= drain_sat;
            bus.out_count <= count_inc;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mul16s_acc_drain.sv
// Bench for mul16s_acc_drain: two instances (SHIFT=0 saturating 32-bit, SHIFT=4 truncating
// 16-bit) share one stimulus and are checked against a plain-integer dot-product model.
module tb_mul16s_acc_drain;
    localparam int ACC_W   = 40;
    localparam int CNT_W   = 16;
    localparam int OUT_W0  = 32;
    localparam int OUT_W1  = 16;
    localparam int SHIFT1  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mul16s_acc_drain_if #(.OUT_W(OUT_W0), .CNT_W(CNT_W)) bus0 ();
    mul16s_acc_drain_if #(.OUT_W(OUT_W1), .CNT_W(CNT_W)) bus1 ();

    mul16s_acc_drain #(.ACC_W(ACC_W), .OUT_W(OUT_W0), .SHIFT(0), .SAT_EN(1), .CNT_W(CNT_W))
        dut0 (.clock(clock), .reset(reset), .bus(bus0));
    mul16s_acc_drain #(.ACC_W(ACC_W), .OUT_W(OUT_W1), .SHIFT(SHIFT1), .SAT_EN(0), .CNT_W(CNT_W))
        dut1 (.clock(clock), .reset(reset), .bus(bus1));

    int     checks = 0;
    int     errors = 0;
    longint sum_q = 0;
    int     cnt_q = 0;
    longint exp_sum = 0;
    int     exp_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference drain: wrap to ACC_W, round half up, shift, then clamp or truncate.
    function automatic longint drain(input longint s_in, input int shift, input bit sat_en,
                                     input int out_w, output bit sat);
        longint s, r, hi, lo;
        s  = (s_in <<< (64 - ACC_W)) >>> (64 - ACC_W);
        r  = (shift > 0) ? ((s + (longint'(1) <<< (shift - 1))) >>> shift) : s;
        hi = (longint'(1) <<< (out_w - 1)) - 1;
        lo = -(longint'(1) <<< (out_w - 1));
        sat = 1'b0;
        if (sat_en) begin
            if (r > hi) begin r = hi; sat = 1'b1; end
            else if (r < lo) begin r = lo; sat = 1'b1; end
        end
        return r & ((longint'(1) <<< out_w) - 1);
    endfunction

    function automatic logic [31:0] rand_prod();
        logic signed [15:0] a, b;
        logic signed [31:0] p;
        if ($urandom_range(0, 3) == 0)
            return ($urandom_range(0, 1) != 0) ? 32'h4000_0000 : 32'hC000_8000;
        a = 16'($urandom);
        b = 16'($urandom);
        p = a * b;
        return p;
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic l,
                         input logic c, input logic r);
        bus0.prod_valid = v; bus0.prod_data = d; bus0.prod_last = l;
        bus0.clear = c;      bus0.out_ready = r;
        bus1.prod_valid = v; bus1.prod_data = d; bus1.prod_last = l;
        bus1.clear = c;      bus1.out_ready = r;
    endtask

    task automatic model_beat(input logic [31:0] d, input bit last, input bit clr);
        if (clr) begin
            sum_q = 0;
            cnt_q = 0;
        end else begin
            sum_q += longint'($signed(d));
            if (cnt_q < CNT_MAX) cnt_q++;
            if (last) begin
                exp_sum = sum_q;
                exp_cnt = cnt_q;
                sum_q   = 0;
                cnt_q   = 0;
            end
        end
    endtask

    task automatic beat(input logic [31:0] d, input bit last);
        drive(1'b1, d, last, 1'b0, 1'b1);
        model_beat(d, last, 1'b0);
        @(negedge clock);
    endtask

    task automatic idle_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
    endtask

    task automatic check_out(input string tag);
        bit     s0, s1;
        longint r0, r1;
        r0 = drain(exp_sum, 0, 1'b1, OUT_W0, s0);
        r1 = drain(exp_sum, SHIFT1, 1'b0, OUT_W1, s1);
        check({tag, "_valid0"}, bus0.out_valid, 1);
        check({tag, "_data0"},  bus0.out_data, r0);
        check({tag, "_sat0"},   bus0.out_sat, s0);
        check({tag, "_count0"}, bus0.out_count, exp_cnt);
        check({tag, "_valid1"}, bus1.out_valid, 1);
        check({tag, "_data1"},  bus1.out_data, r1);
        check({tag, "_sat1"},   bus1.out_sat, s1);
        check({tag, "_count1"}, bus1.out_count, exp_cnt);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid0"}, bus0.out_valid, 0);
        check({tag, "_data0"},  bus0.out_data, 0);
        check({tag, "_sat0"},   bus0.out_sat, 0);
        check({tag, "_count0"}, bus0.out_count, 0);
        check({tag, "_busy0"},  bus0.busy, 0);
        check({tag, "_ready0"}, bus0.prod_ready, 1);
        check({tag, "_valid1"}, bus1.out_valid, 0);
        check({tag, "_data1"},  bus1.out_data, 0);
        check({tag, "_busy1"},  bus1.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          len;
        bit          last, clr;

        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        @(negedge clock);
        check_idle("reset");
        reset = 1'b0;

        // 3 - 5 + 7
        beat(32'd3, 1'b0);
        check("t1_busy0", bus0.busy, 1);
        check("t1_novalid0", bus0.out_valid, 0);
        beat(-32'sd5, 1'b0);
        beat(32'd7, 1'b1);
        check_out("t1");
        check("t1_const", bus0.out_data, 5);
        check("t1_busy_after", bus0.busy, 0);
        idle_cycle();
        check("t1_drained", bus0.out_valid, 0);

        // Saturation at the top of the 32-bit range
        beat(32'h4000_0000, 1'b1);
        check_out("t2a");
        check("t2a_const", bus0.out_data, 32'h4000_0000);
        beat(32'h4000_0000, 1'b0);
        beat(32'h4000_0000, 1'b1);
        check_out("t2b");
        check("t2b_const", bus0.out_data, 32'h7FFF_FFFF);
        check("t2b_sat", bus0.out_sat, 1);

        // Round-half-up shift on the SHIFT=4 instance
        beat(32'd24, 1'b0);
        beat(-32'sd1, 1'b1);
        check_out("t3a");
        check("t3a_const", bus1.out_data, 16'h0001);
        beat(-32'sd24, 1'b1);
        check_out("t3b");
        check("t3b_const", bus1.out_data, 16'hFFFF);
        beat(32'd8, 1'b1);
        check_out("t3c");
        beat(32'd7, 1'b1);
        check_out("t3d");
        idle_cycle();

        // Back-pressure, then a full-rate stream of single-beat results
        drive(1'b1, 32'd100, 1'b1, 1'b0, 1'b0);
        model_beat(32'd100, 1'b1, 1'b0);
        @(negedge clock);
        check_out("hold");
        check("hold_ready", bus0.prod_ready, 0);
        drive(1'b1, 32'd55, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("hold_ready_n", bus0.prod_ready, 0);
            check("hold_valid_n", bus0.out_valid, 1);
            check("hold_data_n", bus0.out_data, 100);
            check("hold_count_n", bus0.out_count, 1);
        end
        for (int i = 0; i < 4; i++) begin
            d = 32'(55 + i * 1000);
            drive(1'b1, d, 1'b1, 1'b0, 1'b1);
            model_beat(d, 1'b1, 1'b0);
            @(negedge clock);
            check_out("stream");
        end
        idle_cycle();
        check("stream_drained", bus0.out_valid, 0);

        // Clear discards a partial sum and a last beat in the same cycle
        beat(32'd10, 1'b0);
        beat(32'd20, 1'b0);
        drive(1'b1, 32'd999, 1'b1, 1'b1, 1'b1);
        model_beat(32'd999, 1'b1, 1'b1);
        @(negedge clock);
        check("clr_busy", bus0.busy, 0);
        check("clr_noload", bus0.out_valid, 0);
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b1);
        check_out("clr");
        check("clr_const", bus0.out_data, 3);
        check("clr_count", bus0.out_count, 2);
        idle_cycle();

        // Asynchronous reset mid-accumulation and with a held result
        beat(32'd5, 1'b0);
        beat(32'd6, 1'b0);
        check("pre_rst_busy", bus0.busy, 1);
        #2;
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        sum_q = 0;
        cnt_q = 0;
        #1;
        check_idle("rst_accum");
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 32'd77, 1'b1, 1'b0, 1'b0);
        model_beat(32'd77, 1'b1, 1'b0);
        @(negedge clock);
        check_out("pre_rst_out");
        #2;
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        check_idle("rst_held");
        @(negedge clock);
        reset = 1'b0;
        beat(32'd9, 1'b1);
        check_out("post_rst");
        check("post_rst_const", bus0.out_data, 9);
        idle_cycle();

        // Random dot products with bubbles and occasional aborts
        for (int k = 0; k < 60; k++) begin
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    drive(1'b0, 32'($urandom), 1'b0, 1'b0, 1'b1);
                    @(negedge clock);
                end
                d    = rand_prod();
                last = (j == len - 1);
                clr  = ($urandom_range(0, 19) == 0);
                drive(1'b1, d, last, clr, 1'b1);
                model_beat(d, last, clr);
                @(negedge clock);
                if (last && !clr) check_out("rand");
                else if (last) check("rand_clr_noload", bus0.out_valid, 0);
            end
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
